// File: rtl/ext_code_pkg.sv
// ext_code_pkg
// Shared types and constants for the external code-memory responder.
//   state_t      : fetch FSM states (IDLE, ADDR, WAIT, DRIVE)
//   FILL_DEFAULT : byte returned for addresses beyond the implemented array
//   WAIT_W       : width of the access-delay counter
package ext_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WAIT  = 2'd2,
    DRIVE = 2'd3
  } state_t;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;
  localparam int         WAIT_W       = 4;

endpackage

// File: rtl/addr_latch_373.sv
// addr_latch_373
// Clocked model of a '373-style transparent address latch. While ale is high
// the latch follows {a_hi, ad_in} every cycle; once ale drops it keeps the
// last value taken, so the low byte survives the bus turning around to data.
// Ports:
//   clk, reset : system clock, synchronous active-high reset (clears to 0)
//   ale        : address latch enable, high = track the bus
//   a_hi       : high address byte
//   ad_in      : multiplexed low address / data byte
//   addr       : latched 16-bit fetch address
module addr_latch_373 (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic [7:0]  a_hi,
  input  logic [7:0]  ad_in,
  output logic [15:0] addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= 16'h0000;
    end else if (ale) begin
      addr <= {a_hi, ad_in};
    end
  end

endmodule

// File: rtl/ext_code_responder.sv
// ext_code_responder
// Memory side of the core's external code-fetch bus: address latch plus an
// EPROM-like byte array with a programmable access delay and a backdoor
// write port used to load code.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   ale, psen_n     : address latch enable / program strobe (active low)
//   ad_in, a_hi     : low address (while ale high) and high address byte
//   data_out        : code byte returned to the core
//   data_oe         : high while the responder drives the bus
//   prog_we/addr/data : backdoor write port (array is never cleared by reset)
//   busy            : state is not IDLE
//   fetch_count     : completed fetches, wrapping
//   protocol_err    : sticky bus-protocol violation flag
module ext_code_responder
  import ext_code_pkg::*;
#(
  parameter int         ADDR_W      = 12,
  parameter int         ACCESS_WAIT = 1,
  parameter logic [7:0] FILL        = FILL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ale,
  input  logic              psen_n,
  input  logic [7:0]        ad_in,
  input  logic [7:0]        a_hi,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic              busy,
  output logic [15:0]       fetch_count,
  output logic              protocol_err
);

  logic [7:0]        mem [2**ADDR_W];
  logic [15:0]       addr;
  logic              in_range;
  logic              ale_d;
  logic              psen_d;
  logic [WAIT_W-1:0] cnt;
  state_t            state;

  addr_latch_373 u_latch (
    .clk   (clk),
    .reset (reset),
    .ale   (ale),
    .a_hi  (a_hi),
    .ad_in (ad_in),
    .addr  (addr)
  );

  assign in_range = ((addr >> ADDR_W) == 16'd0);
  assign busy     = (state != IDLE);

  // No reset on the array: code loaded through the backdoor survives reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
      fetch_count  <= 16'h0000;
      protocol_err <= 1'b0;
      ale_d        <= 1'b0;
      psen_d       <= 1'b1;
    end else begin
      ale_d  <= ale;
      psen_d <= psen_n;
      case (state)
        IDLE: begin
          // ale wins over a simultaneous strobe: the latch is still tracking.
          if (!ale && ale_d) begin
            state <= ADDR;
          end else if (!ale && !psen_n) begin
            protocol_err <= 1'b1;
          end
        end
        ADDR: begin
          if (ale) begin
            state <= IDLE;
          end else if (!psen_n) begin
            state <= WAIT;
            cnt   <= WAIT_W'(ACCESS_WAIT);
          end
        end
        WAIT: begin
          if (ale) begin
            state        <= IDLE;
            data_oe      <= 1'b0;
            protocol_err <= 1'b1;
          end else if (psen_n && !psen_d) begin
            state        <= IDLE;
            protocol_err <= 1'b1;
          end else if (cnt == '0) begin
            // Captured once; later backdoor writes do not disturb the drive.
            state    <= DRIVE;
            data_oe  <= 1'b1;
            data_out <= in_range ? mem[addr[ADDR_W-1:0]] : FILL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (ale) begin
            state        <= IDLE;
            data_oe      <= 1'b0;
            protocol_err <= 1'b1;
          end else if (psen_n) begin
            state       <= IDLE;
            data_oe     <= 1'b0;
            fetch_count <= fetch_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_code_responder.sv
// tb_ext_code_responder
// Transaction-level bench for ext_code_responder: drives complete fetch
// cycles and violations, predicting bytes, counts and flags from a byte-array
// model of the code memory.
module tb_ext_code_responder;

  localparam int AW     = 1;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset, ale, psen_n, prog_we;
  logic [7:0]        ad_in, a_hi, prog_data;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        data_out;
  logic              data_oe, busy, protocol_err;
  logic [15:0]       fetch_count;

  int checks = 0;
  int passed = 0;

  logic [7:0]  mem_m [4096];
  bit          known [4096];
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  ext_code_responder #(.ADDR_W(ADDR_W), .ACCESS_WAIT(AW), .FILL(8'hFF)) dut (
    .clk(clk), .reset(reset), .ale(ale), .psen_n(psen_n), .ad_in(ad_in),
    .a_hi(a_hi), .data_out(data_out), .data_oe(data_oe), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy),
    .fetch_count(fetch_count), .protocol_err(protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_byte(input logic [15:0] a);
    logic [11:0] low;
    low = a[11:0];
    return (a < 16'h1000) ? mem_m[low] : 8'hFF;
  endfunction

  task automatic bk_write(input logic [11:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    mem_m[a] = d; known[a] = 1'b1;
  endtask

  task automatic start_fetch(input logic [15:0] a);
    ale = 1'b1; {a_hi, ad_in} = a;
    tick();
    ale = 1'b0; ad_in = 8'($urandom);
    tick();
    psen_n = 1'b0;
  endtask

  // lat = number of edges from the first sampled psen_n low until data_oe.
  task automatic do_fetch(input logic [15:0] a, input int hold, output int lat,
                          output logic [7:0] b, output bit stable, output logic oe_after);
    start_fetch(a);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (data_oe === 1'b1) begin lat = i; break; end
    end
    b = data_out; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (data_out !== b || data_oe !== 1'b1) stable = 1'b0;
    end
    psen_n = 1'b1;
    tick();
    oe_after = data_oe;
    if (lat > 0) exp_count = exp_count + 16'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ale = 1'b0; psen_n = 1'b1; prog_we = 1'b0;
    ad_in = 8'h00; a_hi = 8'h00; prog_addr = '0; prog_data = 8'h00;
    tick(); tick();
    exp_count = 16'h0000;
    checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else passed++;
    checks++; if (data_oe !== 1'b0) $display("FAIL reset_data_oe got %b want 0", data_oe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %h want 0000", fetch_count); else passed++;
    checks++; if (protocol_err !== 1'b0) $display("FAIL reset_err got %b want 0", protocol_err); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic [7:0] b; bit st; logic oe;
    bk_write(12'h034, 8'hA5);
    do_fetch(16'h0034, 2, lat, b, st, oe);
    checks++; if (lat !== AW + 2) $display("FAIL basic_latency got %0d want %0d", lat, AW + 2); else passed++;
    checks++; if (b !== 8'hA5) $display("FAIL basic_byte got %h want a5", b); else passed++;
    checks++; if (st !== 1'b1) $display("FAIL basic_stable got %b want 1", st); else passed++;
    checks++; if (oe !== 1'b0) $display("FAIL basic_oe_release got %b want 0", oe); else passed++;
    checks++; if (fetch_count !== 16'd1) $display("FAIL basic_count got %h want 0001", fetch_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] b; bit st; logic oe;
    do_fetch(16'h1234, 1, lat, b, st, oe);
    checks++; if (b !== 8'hFF) $display("FAIL oor_byte got %h want ff", b); else passed++;
    checks++; if (fetch_count !== exp_count) $display("FAIL oor_count got %h want %h", fetch_count, exp_count); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] b; bit st; logic oe;
    logic [7:0] want [3];
    logic [15:0] base;
    want[0] = 8'h02; want[1] = 8'h00; want[2] = 8'h10;
    for (int i = 0; i < 3; i++) bk_write(12'(i), want[i]);
    base = exp_count;
    for (int i = 0; i < 3; i++) begin
      do_fetch(16'(i), 0, lat, b, st, oe);
      checks++; if (b !== want[i]) $display("FAIL b2b_byte%0d got %h want %h", i, b, want[i]); else passed++;
    end
    checks++; if (fetch_count - base !== 16'd3) $display("FAIL b2b_count got %0d want 3", fetch_count - base); else passed++;
    checks++; if (protocol_err !== 1'b0) $display("FAIL b2b_err got %b want 0", protocol_err); else passed++;
  endtask

  task automatic test_collision();
    bk_write(12'h055, 8'h3C);
    start_fetch(16'h0055);
    repeat (AW + 1) tick();
    prog_we = 1'b1; prog_addr = 12'h055; prog_data = 8'hC3;
    tick();
    prog_we = 1'b0; mem_m[12'h055] = 8'hC3;
    checks++; if (data_oe !== 1'b1) $display("FAIL collide_oe got %b want 1", data_oe); else passed++;
    checks++; if (data_out !== 8'h3C) $display("FAIL collide_old_byte got %h want 3c", data_out); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL collide_busy got %b want 1", busy); else passed++;
    psen_n = 1'b1;
    tick();
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_random();
    int lat; logic [7:0] b; bit st; logic oe;
    logic [15:0] a; logic [11:0] low; logic [7:0] want;
    int hold;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(16'h1000, 16'hFFFF));
      else a = 16'($urandom_range(0, 4095));
      low = a[11:0];
      if (a < 16'h1000 && (!known[low] || $urandom_range(0, 1) == 1))
        bk_write(low, 8'($urandom));
      want = model_byte(a);
      hold = $urandom_range(0, 3);
      do_fetch(a, hold, lat, b, st, oe);
      checks++; if (lat !== AW + 2) $display("FAIL rand%0d_latency got %0d want %0d", n, lat, AW + 2); else passed++;
      checks++; if (b !== want) $display("FAIL rand%0d_byte addr %h got %h want %h", n, a, b, want); else passed++;
      checks++; if (st !== 1'b1 || oe !== 1'b0) $display("FAIL rand%0d_hold stable %b oe_after %b want 1 0", n, st, oe); else passed++;
      checks++; if (fetch_count !== exp_count) $display("FAIL rand%0d_count got %h want %h", n, fetch_count, exp_count); else passed++;
    end
  endtask

  task automatic test_wrap();
    int lat; logic [7:0] b; bit st; logic oe;
    force dut.fetch_count = 16'hFFFF;
    #1;
    release dut.fetch_count;
    exp_count = 16'hFFFF;
    do_fetch(16'h0034, 0, lat, b, st, oe);
    checks++; if (fetch_count !== 16'h0000) $display("FAIL wrap_count got %h want 0000", fetch_count); else passed++;
    checks++; if (b !== model_byte(16'h0034)) $display("FAIL wrap_byte got %h want %h", b, model_byte(16'h0034)); else passed++;
  endtask

  task automatic test_violations();
    // strobe with no preceding address phase
    reset = 1'b1; tick(); reset = 1'b0; exp_count = 16'h0000;
    psen_n = 1'b0;
    tick();
    checks++; if (protocol_err !== 1'b1) $display("FAIL nale_err got %b want 1", protocol_err); else passed++;
    tick();
    checks++; if (data_oe !== 1'b0 || busy !== 1'b0) $display("FAIL nale_drive oe %b busy %b want 0 0", data_oe, busy); else passed++;
    psen_n = 1'b1; tick();

    // strobe released before data is ready
    reset = 1'b1; tick(); reset = 1'b0;
    start_fetch(16'h0034);
    tick();
    psen_n = 1'b1;
    tick();
    checks++; if (data_oe !== 1'b0) $display("FAIL abort_oe got %b want 0", data_oe); else passed++;
    checks++; if (protocol_err !== 1'b1) $display("FAIL abort_err got %b want 1", protocol_err); else passed++;
    checks++; if (fetch_count !== exp_count) $display("FAIL abort_count got %h want %h", fetch_count, exp_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;

    // ale during drive
    reset = 1'b1; tick(); reset = 1'b0;
    start_fetch(16'h0002);
    for (int i = 0; i < 20 && data_oe !== 1'b1; i++) tick();
    checks++; if (data_oe !== 1'b1) $display("FAIL aledrv_setup got %b want 1", data_oe); else passed++;
    ale = 1'b1;
    tick();
    checks++; if (data_oe !== 1'b0 || protocol_err !== 1'b1) $display("FAIL aledrv oe %b err %b want 0 1", data_oe, protocol_err); else passed++;
    psen_n = 1'b1; ale = 1'b0; tick();

    // ale and strobe together while idle: no error
    reset = 1'b1; tick(); reset = 1'b0;
    ale = 1'b1; psen_n = 1'b0;
    tick(); tick();
    checks++; if (protocol_err !== 1'b0) $display("FAIL ale_prio_err got %b want 0", protocol_err); else passed++;
    psen_n = 1'b1; ale = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    int lat; logic [7:0] b; bit st; logic oe;
    exp_count = 16'h0000;
    do_fetch(16'h0001, 0, lat, b, st, oe);
    start_fetch(16'h0034);
    for (int i = 0; i < 20 && data_oe !== 1'b1; i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (data_oe !== 1'b0 || data_out !== 8'h00) $display("FAIL rstdrv oe %b out %h want 0 00", data_oe, data_out); else passed++;
    checks++; if (busy !== 1'b0 || fetch_count !== 16'h0) $display("FAIL rstdrv busy %b count %h want 0 0000", busy, fetch_count); else passed++;
    reset = 1'b0; psen_n = 1'b1; exp_count = 16'h0000;
    tick();
    do_fetch(16'h0034, 1, lat, b, st, oe);
    checks++; if (b !== model_byte(16'h0034)) $display("FAIL rstdrv_mem got %h want %h", b, model_byte(16'h0034)); else passed++;
    checks++; if (fetch_count !== 16'd1) $display("FAIL rstdrv_count got %h want 0001", fetch_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_back_to_back();
    test_collision();
    test_random();
    test_wrap();
    test_violations();
    test_reset_mid_drive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
